// File: rtl/bounds_range_table.sv
// Range table: inserts inclusive [first,last] bounds at a write pointer, frees
// by base address, and answers registered containment / overflow lookups.
module bounds_range_table #(
   parameter int DEPTH     = 16,
   parameter int AW        = 32,
   parameter bit OVERWRITE = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   // Insert handshake: a transfer happens on a rising edge where ins_valid_i
   // and ins_ready_o are both 1; ready never depends on valid.
   input  logic                     ins_valid_i,
   output logic                     ins_ready_o,
   input  logic [AW-1:0]            ins_first_i,
   input  logic [AW-1:0]            ins_last_i,
   output logic                     ins_err_o,
   input  logic                     free_valid_i,
   input  logic [AW-1:0]            free_base_i,
   output logic                     free_hit_o,
   input  logic                     lk_valid_i,
   input  logic [AW-1:0]            lk_addr_i,
   input  logic [AW-1:0]            lk_base_i,
   output logic                     lk_valid_o,
   output logic                     lk_hit_o,
   output logic                     lk_overflow_o,
   output logic [AW-1:0]            lk_first_o,
   output logic [AW-1:0]            lk_last_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [AW-1:0]            last_first_o,
   output logic [AW-1:0]            last_last_o
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [DEPTH-1:0] valid_q;
   logic [AW-1:0]    first_q [DEPTH];
   logic [AW-1:0]    last_q  [DEPTH];
   logic [IW-1:0]    wptr_q;
   logic [IW-1:0]    prev_ptr;

   logic             ins_fire;
   logic             ins_ok;
   logic             ins_bad;
   logic [DEPTH-1:0] free_match;
   logic             hit_c;
   logic             ovf_c;
   logic [AW-1:0]    hit_first_c;
   logic [AW-1:0]    hit_last_c;
   logic [CW-1:0]    count_c;

   assign ins_ready_o = OVERWRITE ? 1'b1 : !valid_q[wptr_q];
   assign ins_fire    = ins_valid_i && ins_ready_o;
   assign ins_ok      = ins_fire && (ins_first_i <= ins_last_i);
   assign ins_bad     = ins_fire && (ins_first_i > ins_last_i);

   always_comb begin
      free_match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         free_match[i] = free_valid_i && valid_q[i] && (first_q[i] == free_base_i);
      end
   end

   // Scan from the top down so the lowest-index match is the one left standing.
   always_comb begin
      hit_c       = 1'b0;
      ovf_c       = 1'b0;
      hit_first_c = '0;
      hit_last_c  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (valid_q[i] && (first_q[i] <= lk_addr_i) && (lk_addr_i <= last_q[i])) begin
            hit_c       = 1'b1;
            hit_first_c = first_q[i];
            hit_last_c  = last_q[i];
         end
         if (valid_q[i] && (first_q[i] == lk_base_i)) begin
            ovf_c = (lk_addr_i > last_q[i]);
         end
      end
   end

   always_comb begin
      count_c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_c = count_c + CW'(valid_q[i]);
      end
   end

   assign count_o      = count_c;
   assign prev_ptr     = wptr_q - IW'(1);
   assign last_first_o = first_q[prev_ptr];
   assign last_last_o  = last_q[prev_ptr];

   // Insert is written after the free loop so it wins on a shared slot.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         wptr_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            first_q[i] <= '0;
            last_q[i]  <= '0;
         end
      end else if (clear_i) begin
         valid_q <= '0;
         wptr_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            first_q[i] <= '0;
            last_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (free_match[i]) valid_q[i] <= 1'b0;
         end
         if (ins_ok) begin
            valid_q[wptr_q] <= 1'b1;
            first_q[wptr_q] <= ins_first_i;
            last_q[wptr_q]  <= ins_last_i;
            wptr_q          <= wptr_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ins_err_o     <= 1'b0;
         free_hit_o    <= 1'b0;
         lk_valid_o    <= 1'b0;
         lk_hit_o      <= 1'b0;
         lk_overflow_o <= 1'b0;
         lk_first_o    <= '0;
         lk_last_o     <= '0;
      end else begin
         ins_err_o  <= ins_bad && !clear_i;
         free_hit_o <= (|free_match) && !clear_i;
         lk_valid_o <= lk_valid_i;
         if (lk_valid_i) begin
            lk_hit_o      <= hit_c;
            lk_overflow_o <= ovf_c;
            lk_first_o    <= hit_first_c;
            lk_last_o     <= hit_last_c;
         end
      end
   end

endmodule

// File: tb/tb_bounds_range_table.sv
// Directed bench: one reject-mode and one overwrite-mode table (DEPTH=4) share
// the same stimulus; each scenario task checks its own hand-computed values.
module tb_bounds_range_table;

   localparam int AW = 32;
   localparam int DEPTH = 4;
   localparam int CW = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic          ins_valid;
   logic [AW-1:0] ins_first, ins_last;
   logic          free_valid;
   logic [AW-1:0] free_base;
   logic          lk_valid;
   logic [AW-1:0] lk_addr, lk_base;

   // r_* : OVERWRITE=0 instance, o_* : OVERWRITE=1 instance
   logic          r_ready, r_err, r_free_hit, r_lk_valid, r_lk_hit, r_lk_ovf;
   logic [AW-1:0] r_lk_first, r_lk_last, r_last_first, r_last_last;
   logic [CW-1:0] r_count;
   logic          o_ready, o_err, o_free_hit, o_lk_valid, o_lk_hit, o_lk_ovf;
   logic [AW-1:0] o_lk_first, o_lk_last, o_last_first, o_last_last;
   logic [CW-1:0] o_count;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bounds_range_table #(.DEPTH(DEPTH), .AW(AW), .OVERWRITE(1'b0)) u_rej (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .ins_valid_i(ins_valid), .ins_ready_o(r_ready),
      .ins_first_i(ins_first), .ins_last_i(ins_last), .ins_err_o(r_err),
      .free_valid_i(free_valid), .free_base_i(free_base), .free_hit_o(r_free_hit),
      .lk_valid_i(lk_valid), .lk_addr_i(lk_addr), .lk_base_i(lk_base),
      .lk_valid_o(r_lk_valid), .lk_hit_o(r_lk_hit), .lk_overflow_o(r_lk_ovf),
      .lk_first_o(r_lk_first), .lk_last_o(r_lk_last), .count_o(r_count),
      .last_first_o(r_last_first), .last_last_o(r_last_last)
   );

   bounds_range_table #(.DEPTH(DEPTH), .AW(AW), .OVERWRITE(1'b1)) u_ovr (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .ins_valid_i(ins_valid), .ins_ready_o(o_ready),
      .ins_first_i(ins_first), .ins_last_i(ins_last), .ins_err_o(o_err),
      .free_valid_i(free_valid), .free_base_i(free_base), .free_hit_o(o_free_hit),
      .lk_valid_i(lk_valid), .lk_addr_i(lk_addr), .lk_base_i(lk_base),
      .lk_valid_o(o_lk_valid), .lk_hit_o(o_lk_hit), .lk_overflow_o(o_lk_ovf),
      .lk_first_o(o_lk_first), .lk_last_o(o_lk_last), .count_o(o_count),
      .last_first_o(o_last_first), .last_last_o(o_last_last)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_insert(input logic [AW-1:0] f, input logic [AW-1:0] l);
      ins_valid = 1'b1; ins_first = f; ins_last = l;
      tick();
      ins_valid = 1'b0;
   endtask

   task automatic do_lookup(input logic [AW-1:0] a, input logic [AW-1:0] b);
      lk_valid = 1'b1; lk_addr = a; lk_base = b;
      tick();
      lk_valid = 1'b0;
   endtask

   task automatic do_free(input logic [AW-1:0] b);
      free_valid = 1'b1; free_base = b;
      tick();
      free_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (o_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", o_count); end
      n_checks++; if (r_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rej got %b want 1", r_ready); end
      n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_ovr got %b want 1", o_ready); end
      n_checks++; if ({o_lk_valid, o_lk_hit, o_lk_ovf, o_err, o_free_hit} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b want 00000", {o_lk_valid, o_lk_hit, o_lk_ovf, o_err, o_free_hit}); end
      n_checks++; if (o_last_first !== 32'h0) begin n_fail++; $display("FAIL reset_last_first got %h want 0", o_last_first); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_lookup_hit();
      do_insert(32'h1000, 32'h10FF);
      n_checks++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL ins_count got %0d want 1", o_count); end
      n_checks++; if (o_last_first !== 32'h1000 || o_last_last !== 32'h10FF) begin n_fail++; $display("FAIL ins_last got %h/%h want 1000/10ff", o_last_first, o_last_last); end
      do_lookup(32'h1080, 32'h1000);
      n_checks++; if (o_lk_valid !== 1'b1) begin n_fail++; $display("FAIL lk_valid got %b want 1", o_lk_valid); end
      n_checks++; if (o_lk_hit !== 1'b1 || o_lk_ovf !== 1'b0) begin n_fail++; $display("FAIL lk_mid hit/ovf got %b%b want 10", o_lk_hit, o_lk_ovf); end
      n_checks++; if (o_lk_first !== 32'h1000 || o_lk_last !== 32'h10FF) begin n_fail++; $display("FAIL lk_mid bounds got %h/%h want 1000/10ff", o_lk_first, o_lk_last); end
      tick();
      n_checks++; if (o_lk_valid !== 1'b0 || o_lk_hit !== 1'b1) begin n_fail++; $display("FAIL lk_hold valid/hit got %b%b want 01", o_lk_valid, o_lk_hit); end
      do_lookup(32'h10FF, 32'h0);
      n_checks++; if (o_lk_hit !== 1'b1) begin n_fail++; $display("FAIL lk_upper_edge got %b want 1", o_lk_hit); end
      do_lookup(32'h1000, 32'h0);
      n_checks++; if (o_lk_hit !== 1'b1) begin n_fail++; $display("FAIL lk_lower_edge got %b want 1", o_lk_hit); end
      do_lookup(32'h0FFF, 32'h0);
      n_checks++; if (o_lk_hit !== 1'b0 || o_lk_first !== 32'h0) begin n_fail++; $display("FAIL lk_below got %b/%h want 0/0", o_lk_hit, o_lk_first); end
   endtask

   task automatic test_overflow();
      do_lookup(32'h1100, 32'h1000);
      n_checks++; if (o_lk_hit !== 1'b0 || o_lk_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_past hit/ovf got %b%b want 01", o_lk_hit, o_lk_ovf); end
      n_checks++; if (o_lk_first !== 32'h0 || o_lk_last !== 32'h0) begin n_fail++; $display("FAIL ovf_past bounds got %h/%h want 0/0", o_lk_first, o_lk_last); end
      do_lookup(32'h1100, 32'h2000);
      n_checks++; if (o_lk_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_nobase got %b want 0", o_lk_ovf); end
   endtask

   task automatic test_bad_insert();
      do_insert(32'h20, 32'h10);
      n_checks++; if (o_err !== 1'b1 || r_err !== 1'b1) begin n_fail++; $display("FAIL bad_err got %b%b want 11", o_err, r_err); end
      n_checks++; if (o_count !== 3'd1) begin n_fail++; $display("FAIL bad_count got %0d want 1", o_count); end
      n_checks++; if (o_last_first !== 32'h1000) begin n_fail++; $display("FAIL bad_wptr last_first got %h want 1000", o_last_first); end
      tick();
      n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL bad_err_pulse got %b want 0", o_err); end
   endtask

   task automatic test_full_modes();
      do_clear();
      for (int i = 1; i <= 4; i++) do_insert(32'(i * 32'h100), 32'(i * 32'h100 + 32'hFF));
      n_checks++; if (r_count !== 3'd4 || r_ready !== 1'b0) begin n_fail++; $display("FAIL full_rej count/ready got %0d/%b want 4/0", r_count, r_ready); end
      n_checks++; if (o_count !== 3'd4 || o_ready !== 1'b1) begin n_fail++; $display("FAIL full_ovr count/ready got %0d/%b want 4/1", o_count, o_ready); end
      do_insert(32'h500, 32'h5FF);
      n_checks++; if (r_count !== 3'd4 || r_last_first !== 32'h400) begin n_fail++; $display("FAIL fifth_rej count/last got %0d/%h want 4/400", r_count, r_last_first); end
      n_checks++; if (o_count !== 3'd4 || o_last_first !== 32'h500) begin n_fail++; $display("FAIL fifth_ovr count/last got %0d/%h want 4/500", o_count, o_last_first); end
      do_lookup(32'h550, 32'h0);
      n_checks++; if (o_lk_hit !== 1'b1 || o_lk_first !== 32'h500 || r_lk_hit !== 1'b0) begin n_fail++; $display("FAIL fifth_lk ovr %b/%h rej %b want 1/500 0", o_lk_hit, o_lk_first, r_lk_hit); end
      do_lookup(32'h150, 32'h0);
      n_checks++; if (o_lk_hit !== 1'b0 || r_lk_hit !== 1'b1 || r_lk_first !== 32'h100) begin n_fail++; $display("FAIL slot0_lk ovr %b rej %b/%h want 0 1/100", o_lk_hit, r_lk_hit, r_lk_first); end
      do_free(32'h100);
      n_checks++; if (r_free_hit !== 1'b1 || r_count !== 3'd3 || r_ready !== 1'b1) begin n_fail++; $display("FAIL free_rej hit/count/ready got %b/%0d/%b want 1/3/1", r_free_hit, r_count, r_ready); end
      n_checks++; if (o_free_hit !== 1'b0 || o_count !== 3'd4) begin n_fail++; $display("FAIL free_ovr hit/count got %b/%0d want 0/4", o_free_hit, o_count); end
   endtask

   task automatic test_insert_free_same_slot();
      ins_valid = 1'b1; ins_first = 32'h600; ins_last = 32'h6FF;
      free_valid = 1'b1; free_base = 32'h200;
      tick();
      ins_valid = 1'b0; free_valid = 1'b0;
      n_checks++; if (o_count !== 3'd4 || o_last_first !== 32'h600 || o_last_last !== 32'h6FF) begin n_fail++; $display("FAIL same_slot_ovr got %0d/%h/%h want 4/600/6ff", o_count, o_last_first, o_last_last); end
      n_checks++; if (r_count !== 3'd3) begin n_fail++; $display("FAIL same_cycle_rej count got %0d want 3", r_count); end
      do_lookup(32'h650, 32'h0);
      n_checks++; if (o_lk_hit !== 1'b1 || o_lk_first !== 32'h600) begin n_fail++; $display("FAIL same_slot_lk got %b/%h want 1/600", o_lk_hit, o_lk_first); end
      do_lookup(32'h250, 32'h0);
      n_checks++; if (o_lk_hit !== 1'b0) begin n_fail++; $display("FAIL old_range_lk got %b want 0", o_lk_hit); end
      clear = 1'b1; lk_valid = 1'b1; lk_addr = 32'h650; lk_base = 32'h0;
      tick();
      clear = 1'b0; lk_valid = 1'b0;
      n_checks++; if (o_lk_hit !== 1'b1) begin n_fail++; $display("FAIL clear_lk_preedge got %b want 1", o_lk_hit); end
      n_checks++; if (o_count !== 3'd0 || r_count !== 3'd0 || o_last_first !== 32'h0) begin n_fail++; $display("FAIL clear_state got %0d/%0d/%h want 0/0/0", o_count, r_count, o_last_first); end
      do_lookup(32'h650, 32'h0);
      n_checks++; if (o_lk_hit !== 1'b0 || r_lk_hit !== 1'b0) begin n_fail++; $display("FAIL clear_lk got %b%b want 00", o_lk_hit, r_lk_hit); end
   endtask

   task automatic test_multi_free();
      do_insert(32'h700, 32'h70F);
      do_insert(32'h700, 32'h7FF);
      do_lookup(32'h705, 32'h0);
      n_checks++; if (o_lk_last !== 32'h70F) begin n_fail++; $display("FAIL lowest_idx got %h want 70f", o_lk_last); end
      do_lookup(32'h710, 32'h0);
      n_checks++; if (o_lk_hit !== 1'b1 || o_lk_last !== 32'h7FF) begin n_fail++; $display("FAIL second_idx got %b/%h want 1/7ff", o_lk_hit, o_lk_last); end
      do_lookup(32'h750, 32'h700);
      n_checks++; if (o_lk_hit !== 1'b1 || o_lk_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_lowest hit/ovf got %b%b want 11", o_lk_hit, o_lk_ovf); end
      do_free(32'h700);
      n_checks++; if (o_free_hit !== 1'b1 || o_count !== 3'd0) begin n_fail++; $display("FAIL multi_free hit/count got %b/%0d want 1/0", o_free_hit, o_count); end
      tick();
      n_checks++; if (o_free_hit !== 1'b0) begin n_fail++; $display("FAIL free_pulse got %b want 0", o_free_hit); end
   endtask

   task automatic test_reset_mid();
      do_insert(32'h800, 32'h8FF);
      lk_valid = 1'b1; lk_addr = 32'h850; lk_base = 32'h0;
      ins_valid = 1'b1; ins_first = 32'h900; ins_last = 32'h9FF;
      #2 rst_n = 1'b0;
      tick();
      n_checks++; if (o_lk_valid !== 1'b0 || o_lk_hit !== 1'b0) begin n_fail++; $display("FAIL rst_mid lk got %b%b want 00", o_lk_valid, o_lk_hit); end
      n_checks++; if (o_count !== 3'd0 || o_last_first !== 32'h0) begin n_fail++; $display("FAIL rst_mid table got %0d/%h want 0/0", o_count, o_last_first); end
      lk_valid = 1'b0; ins_valid = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0;
      ins_valid = 1'b0; ins_first = '0; ins_last = '0;
      free_valid = 1'b0; free_base = '0;
      lk_valid = 1'b0; lk_addr = '0; lk_base = '0;
      test_reset();
      test_lookup_hit();
      test_overflow();
      test_bad_insert();
      test_full_modes();
      test_insert_free_same_slot();
      test_multi_free();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bounds_range_table.md
BOUNDS_RANGE_TABLE -- requirements
Module: bounds_range_table

Interface
REQ-001 Parameter DEPTH, default 16, SHALL be the number of range entries (power of two, >= 2).
REQ-002 Parameter AW, default 32, SHALL be the address width of every address port.
REQ-003 Parameter OVERWRITE, default 1, SHALL select the full-table mode: 1 = overwrite oldest slot, 0 = reject.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 clear_i  in  1  synchronous clear of the whole table.
REQ-007 ins_valid_i / ins_ready_o  in / out  1 / 1  insert handshake.
REQ-008 ins_first_i, ins_last_i  in  AW each  inclusive range bounds to insert.
REQ-009 ins_err_o  out  1  registered pulse: insert rejected because first > last.
REQ-010 free_valid_i  in  1  free request; free_base_i  in  AW  base address to free.
REQ-011 free_hit_o  out  1  registered pulse: at least one entry was freed.
REQ-012 lk_valid_i  in  1  lookup request; lk_addr_i  in  AW  probe address; lk_base_i  in  AW  pointer base.
REQ-013 lk_valid_o, lk_hit_o, lk_overflow_o  out  1 each  registered lookup result.
REQ-014 lk_first_o, lk_last_o  out  AW each  bounds of the hitting entry.
REQ-015 count_o  out  $clog2(DEPTH)+1  number of valid entries.
REQ-016 last_first_o, last_last_o  out  AW each  bounds of the most recently written slot.

Function
REQ-017 Each entry SHALL hold a valid bit, first and last; a write pointer wptr SHALL select the insert slot.
REQ-018 An insert SHALL occur when ins_valid_i && ins_ready_o && ins_first_i <= ins_last_i: the slot at wptr is written valid, and wptr becomes wptr+1, wrapping from DEPTH-1 to 0.
REQ-019 ins_first_i > ins_last_i SHALL leave the table and wptr unchanged and pulse ins_err_o for one cycle.
REQ-020 OVERWRITE=1 SHALL hold ins_ready_o at 1; an insert into a valid slot replaces it, and count_o is unchanged.
REQ-021 OVERWRITE=0 SHALL drive ins_ready_o = !valid[wptr], combinationally.
REQ-022 A free SHALL invalidate every valid entry whose first equals free_base_i in one edge, and pulse free_hit_o if any matched.
REQ-023 The free SHALL be evaluated on pre-edge contents. On the same slot, a simultaneous insert SHALL win, and that slot ends valid with the new bounds.
REQ-024 count_o SHALL equal the population count of the valid bits after every edge.
REQ-025 A lookup SHALL have a latency of 1 cycle: lk_valid_o equals lk_valid_i delayed by one cycle; the other lk_* outputs update only when lk_valid_i = 1.
REQ-026 lk_hit_o SHALL be 1 if any valid entry satisfies first <= lk_addr_i <= last (unsigned, inclusive).
REQ-027 lk_first_o / lk_last_o SHALL report the lowest-index hitting entry, or 0 if there is no hit.
REQ-028 lk_overflow_o SHALL be 1 if a valid entry with first == lk_base_i exists and lk_addr_i > its last; the lowest-index such entry SHALL be used.
REQ-029 lk_overflow_o SHALL be 0 if no entry with first == lk_base_i exists.
REQ-030 A lookup SHALL see pre-edge table contents; an insert or free in the same cycle SHALL not affect its result.
REQ-031 last_first_o / last_last_o SHALL show the slot at wptr-1 (modulo DEPTH), whether or not that slot is valid.
REQ-032 clear_i SHALL invalidate all entries, zero all bounds and set wptr to 0. It SHALL have priority over insert and free in the same cycle; a lookup in that cycle still returns its pre-edge result.

Reset
REQ-033 On rst_ni = 0, all entries SHALL become invalid with zero bounds, and wptr, count_o, ins_err_o, free_hit_o and all lk_* outputs SHALL be 0.
REQ-034 After reset, ins_ready_o SHALL be 1 in both modes.
REQ-035 Reset asserted mid-operation SHALL abort any pending lookup result (lk_valid_o = 0 next cycle) and discard any same-cycle insert or free.

Verification
REQ-036 Insert [0x1000,0x10FF]; lookup addr 0x1080, base 0x1000 next cycle -> lk_hit_o=1, lk_overflow_o=0, lk_first_o=0x1000, lk_last_o=0x10FF.
REQ-037 Same entry; lookup addr 0x1100, base 0x1000 -> lk_hit_o=0, lk_overflow_o=1; lookup with base 0x2000 -> lk_overflow_o=0.
REQ-038 DEPTH=4, OVERWRITE=0: 4 inserts -> count_o=4, ins_ready_o=0; 5th insert ignored; free base of slot 0 -> free_hit_o=1, count_o=3, ins_ready_o=1.
REQ-039 DEPTH=4, OVERWRITE=1: 5 inserts -> count_o=4, slot 0 holds the 5th range, last_first_o = 5th first.
REQ-040 Insert first=0x20, last=0x10 -> ins_err_o=1 for one cycle, count_o unchanged, wptr unchanged.
REQ-041 Insert into slot k with a same-cycle free matching slot k's old base -> slot k valid with the new bounds; then clear_i -> count_o=0, lk_hit_o=0 for any address.
